// File: rtl/uart_axil_pkg.sv
// Shared types for the UART AXI4-Lite arbiter: register offsets, response
// codes, transaction FSM states and a response classifier.
package uart_axil_pkg;

    localparam logic [3:0] UART_RX   = 4'h0;
    localparam logic [3:0] UART_TX   = 4'h4;
    localparam logic [3:0] UART_STAT = 4'h8;
    localparam logic [3:0] UART_CTRL = 4'hC;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } txn_state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == SLVERR) || (resp == DECERR);
    endfunction

endpackage

// File: rtl/uart_axil_if.sv
// AXI4-Lite port of the UART IP. master = arbiter side, slave = UART side.
interface uart_axil_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    // Every channel uses plain AXI valid/ready: a beat transfers on the clock
    // edge where both are high, and a raised valid stays up until that edge.
    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/uart_axil_txn.sv
// Runs one single-beat AXI4-Lite read or write and reissues it on an error
// response until RETRY_LIMIT extra attempts have been used.
module uart_axil_txn
    import uart_axil_pkg::*;
#(
    parameter int unsigned RETRY_LIMIT = 3,
    parameter logic [3:0]  UART_WSTRB  = 4'b0001
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic        write_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        cmpl_o,
    output logic        cmpl_err_o,
    output logic [31:0] cmpl_rdata_o,
    output txn_state_e  state_o,
    uart_axil_if.master axi
);

    localparam logic [1:0] RL = 2'(RETRY_LIMIT);

    txn_state_e  state_q, state_d;
    logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic        arvalid_q, arvalid_d, rready_q, rready_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic [1:0]  retry_q, retry_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            retry_q   <= retry_d;
        end
    end

    // Address/data registers double as the captured request, so a retry just
    // re-raises the valids without touching them.
    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        retry_d      = retry_q;
        cmpl_o       = 1'b0;
        cmpl_err_o   = 1'b0;
        cmpl_rdata_o = '0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    retry_d = '0;
                    if (write_i) begin
                        awaddr_d  = {28'h0, addr_i};
                        wdata_d   = wdata_i;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        araddr_d  = {28'h0, addr_i};
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = RD;
                    end
                end
            end
            RD: begin
                if (arvalid_q && axi.arready) arvalid_d = 1'b0;
                if (axi.rvalid && rready_q) begin
                    if (!resp_is_err(axi.rresp) || retry_q == RL) begin
                        cmpl_o       = 1'b1;
                        cmpl_err_o   = resp_is_err(axi.rresp);
                        cmpl_rdata_o = axi.rdata;
                        arvalid_d    = 1'b0;
                        rready_d     = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        retry_d   = retry_q + 2'd1;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                if (awvalid_q && axi.awready) awvalid_d = 1'b0;
                if (wvalid_q && axi.wready) wvalid_d = 1'b0;
                if (axi.bvalid && bready_q) begin
                    if (!resp_is_err(axi.bresp) || retry_q == RL) begin
                        cmpl_o     = 1'b1;
                        cmpl_err_o = resp_is_err(axi.bresp);
                        awvalid_d  = 1'b0;
                        wvalid_d   = 1'b0;
                        bready_d   = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        retry_d   = retry_q + 2'd1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign axi.araddr  = araddr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = UART_WSTRB;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign state_o     = state_q;

endmodule

// File: rtl/uart_arbiter.sv
// Round-robin share of the UART AXI4-Lite port between the program loader
// (requester 0) and the core I/O path (requester 1).
module uart_arbiter
    import uart_axil_pkg::*;
#(
    parameter int unsigned RETRY_LIMIT = 3,
    parameter logic [3:0]  UART_WSTRB  = 4'b0001
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [7:0]  req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output txn_state_e  dbg_state_o,
    uart_axil_if.master uart
);

    logic        last_grant_q, owner_q;
    logic [1:0]  req_ready_q, resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        start, g, sel_write;
    logic [3:0]  sel_addr;
    logic [31:0] sel_wdata;
    logic        cmpl, cmpl_err;
    logic [31:0] cmpl_rdata;
    txn_state_e  txn_state;

    // Both pending: the one that did not win last time goes next.
    always_comb begin
        start     = (txn_state == IDLE) && (req_valid != 2'b00);
        g         = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        sel_write = g ? req_write[1]      : req_write[0];
        sel_addr  = g ? req_addr[7:4]     : req_addr[3:0];
        sel_wdata = g ? req_wdata[63:32]  : req_wdata[31:0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            req_ready_q  <= 2'b00;
            resp_valid_q <= 2'b00;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            req_ready_q  <= start ? (g ? 2'b10 : 2'b01) : 2'b00;
            resp_valid_q <= cmpl ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
            if (start) begin
                last_grant_q <= g;
                owner_q      <= g;
            end
            if (cmpl) begin
                resp_rdata_q <= cmpl_rdata;
                resp_err_q   <= cmpl_err;
            end
        end
    end

    uart_axil_txn #(
        .RETRY_LIMIT (RETRY_LIMIT),
        .UART_WSTRB  (UART_WSTRB)
    ) u_txn (
        .clk          (clk),
        .rstn         (rstn),
        .start_i      (start),
        .write_i      (sel_write),
        .addr_i       (sel_addr),
        .wdata_i      (sel_wdata),
        .cmpl_o       (cmpl),
        .cmpl_err_o   (cmpl_err),
        .cmpl_rdata_o (cmpl_rdata),
        .state_o      (txn_state),
        .axi          (uart)
    );

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign dbg_state_o = txn_state;

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter: the bench plays both requesters and the
// UART slave; monitors pop expected grants, AXI beats and responses.
module tb_uart_arbiter;
    import uart_axil_pkg::*;

    localparam int TIMEOUT = 200;

    logic        clk;
    logic        rstn;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    txn_state_e  dbg_state;

    uart_axil_if uart_bus ();

    uart_arbiter #(.RETRY_LIMIT(3), .UART_WSTRB(4'b0001)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .dbg_state_o (dbg_state),
        .uart        (uart_bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // scoreboard
    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [1:0]  exp_grant_q[$];
    logic [31:0] exp_ar_q[$];
    logic [31:0] exp_aw_q[$];
    logic [35:0] exp_w_q[$];
    logic [34:0] exp_resp_q[$];
    int pend[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // monitor: compares whatever the DUT presents against the expected queues
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (req_ready != 2'b00) begin
                    if (exp_grant_q.size() == 0) check("grant_unexpected", 64'(req_ready), 64'h0);
                    else check("grant", 64'(req_ready), 64'(exp_grant_q.pop_front()));
                end
                if (uart_bus.arvalid && uart_bus.arready) begin
                    if (exp_ar_q.size() == 0) check("ar_unexpected", 64'(uart_bus.araddr), 64'hdead_0000);
                    else check("araddr", 64'(uart_bus.araddr), 64'(exp_ar_q.pop_front()));
                end
                if (uart_bus.awvalid && uart_bus.awready) begin
                    if (exp_aw_q.size() == 0) check("aw_unexpected", 64'(uart_bus.awaddr), 64'hdead_0000);
                    else check("awaddr", 64'(uart_bus.awaddr), 64'(exp_aw_q.pop_front()));
                end
                if (uart_bus.wvalid && uart_bus.wready) begin
                    if (exp_w_q.size() == 0) check("w_unexpected", 64'({uart_bus.wstrb, uart_bus.wdata}), 64'hdead_0000);
                    else check("wstrb_wdata", 64'({uart_bus.wstrb, uart_bus.wdata}), 64'(exp_w_q.pop_front()));
                end
                if (resp_valid != 2'b00) begin
                    if (exp_resp_q.size() == 0) check("resp_unexpected", 64'(resp_valid), 64'h0);
                    else check("resp", 64'({resp_valid, resp_err, resp_rdata}), 64'(exp_resp_q.pop_front()));
                end
            end
        end
    end

    // requesters: each holds req_valid until it has seen pend[i] req_ready pulses
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) begin
                    if (pend[i] > 0) pend[i]--;
                    req_valid[i] = (pend[i] > 0);
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input int i, input logic wr, input logic [3:0] addr,
                           input logic [31:0] data, input int n);
        req_write[i]          = wr;
        req_addr[4*i +: 4]    = addr;
        req_wdata[32*i +: 32] = data;
        pend[i]               = n;
        req_valid[i]          = 1'b1;
    endtask

    task automatic serve_read(input int ar_dly, input logic [31:0] data, input logic [1:0] resp);
        int t = 0;
        while (!uart_bus.arvalid && t < TIMEOUT) begin step(); t++; end
        check("arvalid_seen", 64'(uart_bus.arvalid), 64'h1);
        if (!uart_bus.arvalid) return;
        repeat (ar_dly) step();
        uart_bus.arready = 1'b1;
        step();
        uart_bus.arready = 1'b0;
        uart_bus.rdata   = data;
        uart_bus.rresp   = resp;
        uart_bus.rvalid  = 1'b1;
        step();
        uart_bus.rvalid  = 1'b0;
    endtask

    task automatic serve_write(input int aw_at, input int w_at, input int b_at, input logic [1:0] resp);
        int t = 0;
        while (!uart_bus.awvalid && t < TIMEOUT) begin step(); t++; end
        check("awvalid_seen", 64'(uart_bus.awvalid), 64'h1);
        if (!uart_bus.awvalid) return;
        for (int c = 0; c <= b_at; c++) begin
            uart_bus.awready = (c == aw_at);
            uart_bus.wready  = (c == w_at);
            uart_bus.bvalid  = (c == b_at);
            uart_bus.bresp   = resp;
            step();
        end
        uart_bus.awready = 1'b0;
        uart_bus.wready  = 1'b0;
        uart_bus.bvalid  = 1'b0;
    endtask

    task automatic slave_idle();
        uart_bus.arready = 1'b0;
        uart_bus.rvalid  = 1'b0;
        uart_bus.rdata   = '0;
        uart_bus.rresp   = OKAY;
        uart_bus.awready = 1'b0;
        uart_bus.wready  = 1'b0;
        uart_bus.bvalid  = 1'b0;
        uart_bus.bresp   = OKAY;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_axi_valids"}, 64'({uart_bus.arvalid, uart_bus.rready, uart_bus.awvalid,
                                         uart_bus.wvalid, uart_bus.bready}), 64'h0);
        check({tag, "_req_resp"}, 64'({req_ready, resp_valid}), 64'h0);
        check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        pend[0]   = 0;
        pend[1]   = 0;
        slave_idle();
        repeat (3) step();
        rstn = 1'b1;
        @(negedge clk);
        check_quiet("reset");
        check("reset_addr_data", 64'({uart_bus.araddr, uart_bus.awaddr}), 64'h0);
        check("reset_wdata", 64'(uart_bus.wdata), 64'h0);
        check("reset_wstrb", 64'(uart_bus.wstrb), 64'h1);
        check("reset_resp", 64'({resp_err, resp_rdata}), 64'h0);
        step();

        // both requesters pending for two reads each: grants alternate 0,1,0,1
        exp_grant_q = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_ar_q    = '{32'h0, 32'hC, 32'h0, 32'hC};
        exp_resp_q  = '{{2'b01, 1'b0, 32'h100}, {2'b10, 1'b0, 32'h200},
                        {2'b01, 1'b0, 32'h101}, {2'b10, 1'b0, 32'h201}};
        request(0, 1'b0, UART_RX, 32'h0, 2);
        request(1, 1'b0, UART_CTRL, 32'h0, 2);
        serve_read(0, 32'h100, OKAY);
        serve_read(1, 32'h200, OKAY);
        serve_read(0, 32'h101, OKAY);
        serve_read(2, 32'h201, OKAY);
        repeat (4) step();

        // single read by requester 0 from STAT
        exp_grant_q.push_back(2'b01);
        exp_ar_q.push_back(32'h8);
        exp_resp_q.push_back({2'b01, 1'b0, 32'h5});
        request(0, 1'b0, UART_STAT, 32'h0, 1);
        serve_read(0, 32'h5, OKAY);
        repeat (4) step();

        // write by requester 1: W accepted 3 cycles before AW, B 2 cycles later
        exp_grant_q.push_back(2'b10);
        exp_aw_q.push_back(32'h4);
        exp_w_q.push_back({4'b0001, 32'h41});
        exp_resp_q.push_back({2'b10, 1'b0, 32'h0});
        request(1, 1'b1, UART_TX, 32'h41, 1);
        serve_write(3, 0, 5, OKAY);
        repeat (4) step();

        // two SLVERR responses then OKAY: AW/W reissued with the same contents
        exp_grant_q.push_back(2'b01);
        repeat (3) begin
            exp_aw_q.push_back(32'hC);
            exp_w_q.push_back({4'b0001, 32'h3});
        end
        exp_resp_q.push_back({2'b01, 1'b0, 32'h0});
        request(0, 1'b1, UART_CTRL, 32'h3, 1);
        serve_write(0, 0, 1, SLVERR);
        serve_write(1, 0, 2, SLVERR);
        serve_write(0, 1, 1, OKAY);
        repeat (4) step();

        // every attempt errors: 1 + 3 AR handshakes then an error response
        exp_grant_q.push_back(2'b10);
        repeat (4) exp_ar_q.push_back(32'h8);
        exp_resp_q.push_back({2'b10, 1'b1, 32'hDEAD});
        request(1, 1'b0, UART_STAT, 32'h0, 1);
        serve_read(0, 32'hDEAD, SLVERR);
        serve_read(1, 32'hDEAD, DECERR);
        serve_read(0, 32'hDEAD, SLVERR);
        serve_read(0, 32'hDEAD, SLVERR);
        repeat (4) step();

        // reset after AW accepted: write abandoned without any response
        exp_grant_q.push_back(2'b01);
        exp_aw_q.push_back(32'h4);
        request(0, 1'b1, UART_TX, 32'h55, 1);
        begin
            int t = 0;
            while (!uart_bus.awvalid && t < TIMEOUT) begin step(); t++; end
        end
        check("awvalid_seen", 64'(uart_bus.awvalid), 64'h1);
        uart_bus.awready = 1'b1;
        step();
        uart_bus.awready = 1'b0;
        rstn      = 1'b0;
        req_valid = 2'b00;
        pend[0]   = 0;
        pend[1]   = 0;
        slave_idle();
        step();
        check_quiet("midreset");
        step();
        rstn = 1'b1;
        step();

        // after reset requester 0 wins again even though it was granted last
        exp_grant_q.push_back(2'b01);
        exp_grant_q.push_back(2'b10);
        exp_ar_q.push_back(32'h0);
        exp_ar_q.push_back(32'h8);
        exp_resp_q.push_back({2'b01, 1'b0, 32'h77});
        exp_resp_q.push_back({2'b10, 1'b0, 32'h88});
        request(0, 1'b0, UART_RX, 32'h0, 1);
        request(1, 1'b0, UART_STAT, 32'h0, 1);
        serve_read(0, 32'h77, OKAY);
        serve_read(0, 32'h88, OKAY);
        repeat (5) step();

        check("grant_q_drained", 64'(exp_grant_q.size()), 64'h0);
        check("ar_q_drained", 64'(exp_ar_q.size()), 64'h0);
        check("aw_q_drained", 64'(exp_aw_q.size()), 64'h0);
        check("w_q_drained", 64'(exp_w_q.size()), 64'h0);
        check("resp_q_drained", 64'(exp_resp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
